// File: rtl/key_debounce_bank.sv
// key_debounce_bank: per-channel two-flop synchroniser, stability-counter
// debouncer and registered press/release edge pulses. The optional
// auto-repeat generator is enabled by defining KEY_DEBOUNCE_BANK_REPEAT_EN.
// Without that macro, repeat_pulse is tied to 0.
module key_debounce_bank #(
    parameter int WIDTH         = 4,
    parameter int DEPTH_W       = 16,
    parameter int INVERT        = 1,
    parameter int REPEAT_DELAY  = 1000,
    parameter int REPEAT_PERIOD = 250
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] released,
    output logic [WIDTH-1:0] repeat_pulse,
    output logic             any_change
);

    // Value that a released key presents on raw.
    localparam logic               IDLE    = (INVERT != 0);
    localparam logic [DEPTH_W-1:0] CNT_MAX = '1;

    // The repeat timing would be meaningless below two cycles, so reject
    // such parameters at elaboration.
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 || DEPTH_W < 1 || WIDTH < 1) begin : g_bad_params
        $error("key_debounce_bank: illegal parameter value");
    end

    logic [WIDTH-1:0]              sync1;
    logic [WIDTH-1:0]              sync2;
    logic [WIDTH-1:0]              sample;
    logic [WIDTH-1:0][DEPTH_W-1:0] cnt;
    logic [WIDTH-1:0][DEPTH_W-1:0] cnt_nxt;
    logic [WIDTH-1:0]              level_nxt;
    logic [WIDTH-1:0]              rise;
    logic [WIDTH-1:0]              fall;

    // Two-flop synchroniser. Reset loads the idle raw value so that leaving
    // reset looks like "nothing pressed".
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: registers take non-blocking assignments, so every flop
        // samples the pre-edge value of its neighbours.
        if (!reset) begin
            sync1 <= {WIDTH{IDLE}};
            sync2 <= {WIDTH{IDLE}};
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Logical sample: 1 means pressed, whatever the key polarity.
    assign sample = sync2 ^ {WIDTH{IDLE}};

    // Stability counting. A disagreement held through MAX counted cycles
    // commits the new level. Any agreement restarts the count.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a
        // value unassigned and no latch is inferred.
        level_nxt = level;
        cnt_nxt   = '0;
        rise      = '0;
        fall      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sample[i] != level[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    level_nxt[i] = sample[i];
                    rise[i]      = sample[i];
                    fall[i]      = ~sample[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state and registered edge pulses. These appear in the same
    // cycle as the new level.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the counter array is reset explicitly. A partial count that
        // survived reset could commit a level change too early.
        if (!reset) begin
            cnt        <= '0;
            level      <= '0;
            pressed    <= '0;
            released   <= '0;
            any_change <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            level      <= level_nxt;
            pressed    <= rise;
            released   <= fall;
            any_change <= |(rise | fall);
        end
    end

`ifdef KEY_DEBOUNCE_BANK_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [WIDTH-1:0][RW-1:0] rcnt;
    logic [WIDTH-1:0]         rphase;

    // Auto-repeat. The counter starts on the press edge. The first pulse
    // comes REPEAT_DELAY cycles later, then one pulse every REPEAT_PERIOD
    // cycles. A key that is (or is about to be) released clears everything
    // on that same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rcnt         <= '0;
            rphase       <= '0;
            repeat_pulse <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!level_nxt[i] || rise[i]) begin
                    rcnt[i]         <= '0;
                    rphase[i]       <= 1'b0;
                    repeat_pulse[i] <= 1'b0;
                end else if (rcnt[i] == (rphase[i] ? PERIOD_LAST : DELAY_LAST)) begin
                    rcnt[i]         <= '0;
                    rphase[i]       <= 1'b1;
                    repeat_pulse[i] <= 1'b1;
                end else begin
                    rcnt[i]         <= rcnt[i] + 1'b1;
                    repeat_pulse[i] <= 1'b0;
                end
            end
        end
    end
`else
    assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_key_debounce_bank.sv
// Testbench for key_debounce_bank (WIDTH=4, DEPTH_W=2, INVERT=1, REPEAT_DELAY=8,
// REPEAT_PERIOD=4). Each scenario pushes per-cycle expected output vectors to
// a scoreboard queue, drives raw/reset on falling edges, and pops/compares at
// each falling edge. Cycle k of a scenario is the k-th rising edge after the
// scenario's first stimulus slot. A key changed at slot j shows its new level
// at k = j + 6.
module tb_key_debounce_bank;

    localparam int WIDTH  = 4;
    localparam int DELAY  = 8;
    localparam int PERIOD = 4;
    localparam int NEVER  = 100000;
`ifdef KEY_DEBOUNCE_BANK_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] level, pressed, released, repeat_pulse;
    logic             any_change;
    logic [16:0]      obs;
    logic [16:0]      exp_q[$];
    logic [16:0]      e;

    int n_compared   = 0;
    int n_mismatched = 0;

    key_debounce_bank #(
        .WIDTH(WIDTH), .DEPTH_W(2), .INVERT(1),
        .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)
    ) dut (
        .clk(clk), .reset(reset), .raw(raw),
        .level(level), .pressed(pressed), .released(released),
        .repeat_pulse(repeat_pulse), .any_change(any_change)
    );

    always #5 clk = ~clk;

    assign obs = {level, pressed, released, repeat_pulse, any_change};

    // Expected outputs at cycle k for channels in mask. The level is visible
    // from kp up to kr-1. Repeat pulses arrive at kp+DELAY, then every PERIOD
    // cycles, always strictly before kr.
    function automatic logic [16:0] model(int k, int kp, int kr, logic [3:0] mask);
        logic [3:0] l, p, r, rp;
        l  = (k >= kp && k < kr) ? mask : 4'b0;
        p  = (k == kp) ? mask : 4'b0;
        r  = (k == kr) ? mask : 4'b0;
        rp = (REP && k < kr && k >= kp + DELAY && ((k - kp - DELAY) % PERIOD) == 0) ? mask : 4'b0;
        return {l, p, r, rp, |(p | r)};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        raw   = 4'hF;
        #3;
        n_compared++;
        if (obs !== 17'h0) begin
            n_mismatched++;
            $display("FAIL reset_async got=%h exp=%h", obs, 17'h0);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 10; k++) exp_q.push_back(17'h0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_compared++;
            if (obs !== e) begin
                n_mismatched++;
                $display("FAIL reset_idle k=%0d got=%h exp=%h", k, obs, e);
            end
        end
    endtask

    task automatic test_press();
        for (int k = 1; k <= 22; k++) exp_q.push_back(model(k, 6, 18, 4'b0010));
        for (int k = 0; k <= 22; k++) begin
            if (k > 0) begin
                @(negedge clk);
                e = exp_q.pop_front();
                n_compared++;
                if (obs !== e) begin
                    n_mismatched++;
                    $display("FAIL press k=%0d got=%h exp=%h", k, obs, e);
                end
            end
            if (k == 0)  raw[1] = 1'b0;
            if (k == 12) raw[1] = 1'b1;
        end
    endtask

    task automatic test_glitch();
        for (int k = 1; k <= 28; k++) exp_q.push_back(model(k, 18, 26, 4'b0100));
        for (int k = 0; k <= 28; k++) begin
            if (k > 0) begin
                @(negedge clk);
                e = exp_q.pop_front();
                n_compared++;
                if (obs !== e) begin
                    n_mismatched++;
                    $display("FAIL glitch k=%0d got=%h exp=%h", k, obs, e);
                end
            end
            if (k == 0)  raw[2] = 1'b0;
            if (k == 3)  raw[2] = 1'b1;
            if (k == 12) raw[2] = 1'b0;
            if (k == 20) raw[2] = 1'b1;
        end
    endtask

    task automatic test_simultaneous();
        for (int k = 1; k <= 28; k++) exp_q.push_back(model(k, 6, 26, 4'b1001));
        for (int k = 0; k <= 28; k++) begin
            if (k > 0) begin
                @(negedge clk);
                e = exp_q.pop_front();
                n_compared++;
                if (obs !== e) begin
                    n_mismatched++;
                    $display("FAIL simultaneous k=%0d got=%h exp=%h", k, obs, e);
                end
            end
            if (k == 0)  raw = 4'b0110;
            if (k == 20) raw = 4'b1111;
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 1; k <= 20; k++) exp_q.push_back(model(k, 9, 18, 4'b0010));
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) begin
                @(negedge clk);
                e = exp_q.pop_front();
                n_compared++;
                if (obs !== e) begin
                    n_mismatched++;
                    $display("FAIL reset_mid k=%0d got=%h exp=%h", k, obs, e);
                end
            end
            if (k == 0)  raw[1] = 1'b0;
            if (k == 2)  reset  = 1'b0;
            if (k == 3)  reset  = 1'b1;
            if (k == 12) raw[1] = 1'b1;
        end
    endtask

    task automatic test_repeat();
        for (int k = 1; k <= 40; k++) exp_q.push_back(model(k, 6, 36, 4'b0010));
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) begin
                @(negedge clk);
                e = exp_q.pop_front();
                n_compared++;
                if (obs !== e) begin
                    n_mismatched++;
                    $display("FAIL repeat k=%0d got=%h exp=%h", k, obs, e);
                end
            end
            if (k == 0)  raw[1] = 1'b0;
            if (k == 30) raw[1] = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_repeat();
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/key_debounce_bank.md
KEY_DEBOUNCE_BANK -- requirements
Module: key_debounce_bank

Interface
REQ-001 Parameter WIDTH, default 4: number of independent input channels.
REQ-002 Parameter DEPTH_W, default 16: stability counter width; MAX = 2**DEPTH_W - 1.
REQ-003 Parameter INVERT, default 1: 1 = raw inputs active-low, 0 = active-high.
REQ-004 Parameter REPEAT_DELAY, default 1000: cycles from press pulse to first repeat pulse, minimum 2.
REQ-005 Parameter REPEAT_PERIOD, default 250: cycles between subsequent repeat pulses, minimum 2.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 raw  input  WIDTH  asynchronous key/switch inputs.
REQ-009 level  output  WIDTH  debounced logical state, 1 = pressed.
REQ-010 pressed  output  WIDTH  one-cycle pulse on each 0->1 change of level.
REQ-011 released  output  WIDTH  one-cycle pulse on each 1->0 change of level.
REQ-012 repeat_pulse  output  WIDTH  one-cycle auto-repeat pulses while held.
REQ-013 any_change  output  1  OR of pressed and released, same cycle.

Function
REQ-014 Each channel has a 2-flop synchroniser; the logical sample s = sync2 XOR INVERT.
REQ-015 Each channel has a DEPTH_W-bit counter: cleared on any edge where s == level, incremented on any edge where s != level and counter < MAX.
REQ-016 On an edge where s != level and counter == MAX: level <= s, counter <= 0.
REQ-017 Latency: raw stable from edge E0 onward makes level change visible after edge E0 + 1 + 2**DEPTH_W.
REQ-018 A glitch shorter than MAX+1 synchronised cycles produces no level change and no pulse; counter restarts from 0.
REQ-019 pressed/released are registered and asserted in the same cycle the new level value first appears, for exactly one cycle.
REQ-020 Channels are fully independent; simultaneous changes on several channels produce simultaneous pulses.
REQ-021 Counter never wraps; saturation at MAX is impossible because REQ-016 fires first.

Reset
REQ-022 reset low asynchronously forces: sync flops to the idle raw value (INVERT ? 1 : 0); counters, repeat counters, level, pressed, released, repeat_pulse, any_change to 0.
REQ-023 After release of reset with raw idle, no pulse is produced on any output.
REQ-024 Reset asserted mid-count discards the partial count; counting restarts from 0 after reset release.

Configuration
REQ-025 Macro KEY_DEBOUNCE_BANK_REPEAT_EN defined: each channel has a repeat counter; repeat_pulse asserts REPEAT_DELAY cycles after the pressed pulse, then every REPEAT_PERIOD cycles while level stays 1.
REQ-026 With the macro, level falling clears the repeat counter within the same edge; no repeat_pulse in or after the released cycle.
REQ-027 With the macro, repeat_pulse is never asserted in the same cycle as pressed.
REQ-028 Macro undefined: no repeat logic is synthesised; repeat_pulse is constant 0; all other behaviour identical.

Verification (WIDTH=4, DEPTH_W=2, INVERT=1, REPEAT_DELAY=8, REPEAT_PERIOD=4)
REQ-029 raw[1] 1->0 before edge E0, held -> level[1]=1 and pressed[1]=1, any_change=1 after E5; pressed[1]=0 after E6.
REQ-030 raw[2] low for 3 cycles then high -> level, pressed, released stay 0 throughout.
REQ-031 raw[0] and raw[3] pressed at the same edge, then released together 20 cycles later -> simultaneous pressed[0], pressed[3], then simultaneous released[0], released[3], each one cycle wide.
REQ-032 reset low 2 cycles after raw[1] falls, released 1 cycle later with raw[1] still low -> all outputs 0 during reset; level[1] rises 5 edges after the first edge following reset release.
REQ-033 With KEY_DEBOUNCE_BANK_REPEAT_EN, raw[1] held low for 30 cycles after the pressed pulse at cycle P -> repeat_pulse[1] at P+8, P+12, P+16, ..., none after release; without the macro repeat_pulse stays 0.
